// File: rtl/fib_gen_pkg.sv
// Shared types and sizing helpers for the fib_gen recurrence generator.
package fib_gen_pkg;

  // Guard bits above WIDTH so the widest step (2*y + x) never loses its carry.
  localparam int unsigned GUARD_W = 2;

  typedef enum logic [1:0] {
    FIB  = 2'b00,
    PELL = 2'b01,
    REV  = 2'b10,
    HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  // Width of the widened arithmetic path for a given term width.
  function automatic int unsigned wide_w(input int unsigned width);
    return width + GUARD_W;
  endfunction

endpackage

// File: rtl/fib_gen_alu.sv
// Combinational step function for fib_gen.
//   x_i, y_i     : current pair
//   mode_i       : FIB / PELL / REV / HOLD
//   x_next_c     : next x (after wrap or clamp)
//   y_next_c     : next y (after wrap or clamp)
//   ovf_c        : carry above WIDTH-1 or REV underflow
//   clamp_c      : saturating clamp applied (ovf_c with SATURATE set)
module fib_gen_alu
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 11,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] x_next_c,
  output logic [WIDTH-1:0] y_next_c,
  output logic             ovf_c,
  output logic             clamp_c
);

  localparam int unsigned WW = wide_w(WIDTH);

  logic [WW-1:0] xw;
  logic [WW-1:0] yw;
  logic [WW-1:0] res_w;

  // Widened step; REV underflow shows up as the sign bit of the difference.
  always_comb begin
    xw       = WW'(x_i);
    yw       = WW'(y_i);
    res_w    = '0;
    x_next_c = x_i;
    y_next_c = y_i;
    ovf_c    = 1'b0;
    unique case (mode_i)
      FIB: begin
        res_w    = xw + yw;
        x_next_c = y_i;
        y_next_c = res_w[WIDTH-1:0];
        ovf_c    = |res_w[WW-1:WIDTH];
      end
      PELL: begin
        res_w    = (yw << 1) + xw;
        x_next_c = y_i;
        y_next_c = res_w[WIDTH-1:0];
        ovf_c    = |res_w[WW-1:WIDTH];
      end
      REV: begin
        res_w    = yw - xw;
        x_next_c = res_w[WIDTH-1:0];
        y_next_c = x_i;
        ovf_c    = res_w[WW-1];
      end
      default: ;
    endcase

    clamp_c = SATURATE && ovf_c;
    // Only the register that overflowed is clamped; the other shifts normally.
    if (clamp_c) begin
      if (mode_i == REV) x_next_c = '0;
      else               y_next_c = '1;
    end
  end

endmodule

// File: rtl/fib_gen.sv
// Two-register recurrence generator (Fibonacci / Pell / reverse-Fibonacci).
//   clk, rst        : clock, synchronous active-high reset
//   selector        : step enable
//   mode            : step function (FIB, PELL, REV, HOLD)
//   load, load_x/y  : seed load, overrides stepping
//   x, y            : current pair
//   steps           : accepted steps since reset/load, saturating
//   ovf             : sticky wrap/clamp flag
//   locked          : generator frozen after a saturating overflow
//   out_valid       : pulse after each accepted step
module fib_gen
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 11,
  parameter int unsigned CNT_W    = 16,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned SEED_X   = 1,
  parameter int unsigned SEED_Y   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] steps,
  output logic             ovf,
  output logic             locked,
  output logic             out_valid
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  mode_t              mode_s;
  logic               step_c;
  logic [WIDTH-1:0]   alu_x_c;
  logic [WIDTH-1:0]   alu_y_c;
  logic               alu_ovf_c;
  logic               alu_clamp_c;

  assign mode_s = mode_t'(mode);
  assign step_c = selector && (mode_s != HOLD) && (state_q == S_RUN);

  fib_gen_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .x_i      (x_q),
    .y_i      (y_q),
    .mode_i   (mode_s),
    .x_next_c (alu_x_c),
    .y_next_c (alu_y_c),
    .ovf_c    (alu_ovf_c),
    .clamp_c  (alu_clamp_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      x_q     <= WIDTH'(SEED_X);
      y_q     <= WIDTH'(SEED_Y);
      steps_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      steps_q <= steps_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: load beats step; a clamped step is still accepted, then locks.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    steps_d = steps_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (load) begin
      state_d = S_RUN;
      x_d     = load_x;
      y_d     = load_y;
      steps_d = '0;
      ovf_d   = 1'b0;
    end else if (step_c) begin
      x_d     = alu_x_c;
      y_d     = alu_y_c;
      valid_d = 1'b1;
      if (steps_q != '1) steps_d = steps_q + CNT_W'(1);
      if (alu_ovf_c)     ovf_d   = 1'b1;
      if (alu_clamp_c)   state_d = S_LOCK;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign steps     = steps_q;
  assign ovf       = ovf_q;
  assign locked    = (state_q == S_LOCK);
  assign out_valid = valid_q;

endmodule

// File: doc/fib_gen.md
# fib_gen

Parametrised two-register recurrence generator, the successor of the fixed 11-bit Fibonacci `top`. Holds the pair (x, y) and advances it one step per enabled cycle. Runtime modes are Fibonacci, Pell and reverse-Fibonacci. The block also provides seed loading, a step counter, a sticky overflow flag and a per-step valid strobe. It sits in the simple_arithmetic_cases suite as the generalised DUT for property mining with random `selector` stimulus.

## Interface
- `WIDTH`, 11: width of x and y.
- `CNT_W`, 16: width of the step counter.
- `SATURATE`, 0: overflow policy. 0 means wrap modulo 2^WIDTH; 1 means clamp and lock.
- `SEED_X`, 1: reset value of x.
- `SEED_Y`, 1: reset value of y.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `selector` in 1: step enable, sampled every edge.
- `mode` in 2: step function. 00 = FIB, 01 = PELL, 10 = REV, 11 = HOLD.
- `load` in 1: load seeds from `load_x` / `load_y`.
- `load_x` in WIDTH: seed for x.
- `load_y` in WIDTH: seed for y.
- `x` out WIDTH: current first term.
- `y` out WIDTH: current second term.
- `steps` out CNT_W: accepted steps since reset or load; saturates at all-ones.
- `ovf` out 1: sticky flag, set on any wrap or clamp.
- `locked` out 1: high while in S_LOCK.
- `out_valid` out 1: one-cycle pulse after each accepted step.

## Operation
- Reset values:
  - x = SEED_X, y = SEED_Y
  - steps = 0, ovf = 0, locked = 0, out_valid = 0
  - state = S_RUN
- Priority per edge is `rst` > `load` > step.
- Load:
  - x <= load_x, y <= load_y.
  - steps <= 0, ovf <= 0, out_valid <= 0.
  - State returns to S_RUN; a load is the only exit from S_LOCK apart from `rst`.
- Step accepted when `selector`=1, `mode`≠HOLD, state = S_RUN, and no load or reset is active.
- Step functions, computed at WIDTH+2 bits:
  - FIB: x' = y, y' = x + y.
  - PELL: x' = y, y' = 2·y + x.
  - REV: x' = y − x, y' = x. Underflow when y < x.
- Overflow handling:
  - An overflow is any carry above bit WIDTH−1, or a REV underflow.
  - SATURATE=0: result truncated to WIDTH bits; ovf <= 1; state stays S_RUN.
  - SATURATE=1: y' clamps to 2^WIDTH−1 (FIB/PELL) or x' clamps to 0 (REV). The other register updates normally. ovf <= 1; next state S_LOCK.
- HOLD mode, or `selector`=0: registers unchanged, no step counted, out_valid <= 0.
- In S_LOCK:
  - `selector` and `mode` are ignored.
  - x and y are frozen; steps does not increment.

## Timing
- Every output is a register with 1-cycle latency.
- Inputs sampled at edge N are reflected in the outputs after edge N.
- out_valid is high exactly in the cycle following an accepted step. Back-to-back steps give continuous out_valid.
- The step that causes a saturating overflow is itself accepted: out_valid = 1, steps increments, and locked rises in the same cycle.
- Simultaneous `load` and `selector`: only the load takes effect.
- `rst` mid-run or in S_LOCK: state and outputs take their reset values after the next edge.
- steps at all-ones stays all-ones; it never sets ovf.

## Structure
- Package `fib_gen_pkg` contains:
  - `mode_t` enum (FIB, PELL, REV, HOLD)
  - `state_t` enum (S_RUN, S_LOCK)
  - a helper constant for the widened arithmetic width, WIDTH+2
- Sub-module `fib_gen_alu`: combinational. Takes (x, y, mode) and returns (x_next, y_next, carry/underflow, clamp-applied), parametrised by WIDTH and SATURATE.
- The top level owns the FSM, the counter, the flags and out_valid.

## Test plan
All scenarios use default parameters unless stated.
- **FIB wrap:**
  - Stimulus: reset, then mode=FIB, selector=1 for 15 cycles.
  - After 15 steps: x=987, y=1597, steps=15, ovf=0.
  - One further step: x=1597, y=536, ovf=1, locked=0.
- **FIB saturate:** same stimulus with SATURATE=1. The 16th step gives x=1597, y=2047, ovf=1, locked=1. Further selector pulses leave x, y and steps=16 unchanged, with out_valid=0.
- **PELL:** load (0,1), then 4 steps in PELL. Result x=12, y=29, steps=4, with out_valid high for 4 consecutive cycles.
- **REV:**
  - Load (987,1597), then 1 REV step: x=610, y=987.
  - Load (5,3), then 1 REV step: wraps to x=2046, y=5, ovf=1.
- **Priority:**
  - load=1 with selector=1 in the same cycle: the load values appear, steps=0, out_valid=0.
  - From S_LOCK, a load restores S_RUN with locked=0.
- **Reset mid-run:** rst=1 during a 10-step FIB run with selector held high. Next cycle shows x=1, y=1, steps=0, ovf=0, out_valid=0; stepping resumes on the first cycle after rst drops.
